// File: rtl/serial_add_8bit.sv
// serial_add_8bit: bit-serial 8-bit adder computing a + b + c_in, LSB first,
// one bit per clock through a single full-adder cell, a carry flip-flop and
// a 3-bit bit counter. A start/done handshake wraps each operation, and the
// last result is held on s/c_out until the next completed add.
module serial_add_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] s,
    output logic       c_out,
    output logic       busy,
    output logic       done
);

    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operand shift registers; bit 0 always holds the bit being added.
    logic [DATA_W-1:0] sh_a;
    logic [DATA_W-1:0] sh_b;
    // Sum bits enter at the MSB so that after eight shifts bit 0 is the LSB.
    logic [DATA_W-1:0] sum_sh;
    logic              carry;
    logic [CNT_W-1:0]  cnt;

    logic              accept;
    logic              last_bit;
    logic              fa_sum;
    logic              fa_carry;

    // Full-adder sum output.
    function automatic logic fa_s(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    // Full-adder carry output: majority of the three inputs.
    function automatic logic fa_maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // The single full-adder cell working on the current LSBs and the carry.
    always_comb begin
        fa_sum   = fa_s(sh_a[0], sh_b[0], carry);
        fa_carry = fa_maj(sh_a[0], sh_b[0], carry);
    end

    // Handshake qualifiers: start counts only in IDLE, cnt==7 is the last bit.
    always_comb begin
        accept   = (state == IDLE) && start;
        last_bit = (state == SHIFT) && (cnt == CNT_W'(DATA_W - 1));
    end

    // State register; rst wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and status outputs decoded from the current state.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // start here is deliberately dropped; no request is queued.
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Serial datapath: load on accept, shift one bit per SHIFT cycle, and
    // publish the full result only on the final bit so s/c_out never show
    // a partial sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a   <= '0;
            sh_b   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s      <= '0;
            c_out  <= 1'b0;
        end else if (accept) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= c_in;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            sh_a   <= sh_a >> 1;
            sh_b   <= sh_b >> 1;
            sum_sh <= {fa_sum, sum_sh[DATA_W-1:1]};
            carry  <= fa_carry;
            // Wraps 7 -> 0 on the same edge that enters DONE.
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
                s     <= {fa_sum, sum_sh[DATA_W-1:1]};
                c_out <= fa_carry;
            end
        end
    end

endmodule
